uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

Asynchronous serial receiver feeding the CSL message decoder. It oversamples the incoming UART line (8 data bits, no parity, 1 stop bit, LSB first) with the system clock. For each valid frame it delivers one byte on `rx_msg` with a single-cycle `rx_complete` strobe. The decoder advances exactly one state per strobe, so the one-pulse-per-byte guarantee is mandatory.

## Interface
- `CLKS_PER_BIT`, default 434, system clocks per bit period (50 MHz / 115200). Legal range is 4 to 65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock, reset asynchronous active-low.
- `rx`  in  1  raw serial line; idle is high; asynchronous to `clk`.
- `rx_msg`  out  8  last correctly received byte.
- `rx_complete`  out  1  one-cycle strobe; `rx_msg` is valid and new in this cycle.
- `rx_frame_err`  out  1  one-cycle strobe; the stop bit was sampled low.
- `rx_busy`  out  1  high from start-bit detection until return to IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- Define H = CLKS_PER_BIT/2 (integer division). The bit counter is 16 bits, the bit index is 3 bits, and the shift register is 8 bits.
- **IDLE:**
  - The counter is held at 0.
  - When `rx_s == 0`, go to START; the counter starts at 0.
- **START:**
  - At counter == H-1, sample `rx_s`.
  - If `rx_s` is 0, go to DATA with the counter cleared.
  - If `rx_s` is 1 (glitch), go to IDLE silently, with no strobe of any kind.
- **DATA:**
  - At each counter == CLKS_PER_BIT-1, shift `rx_s` into bit[idx] (LSB first), clear the counter, and increment idx.
  - After idx 7, go to STOP.
- **STOP:**
  - At counter == CLKS_PER_BIT-1, sample `rx_s`.
  - If 1: load the shift register into `rx_msg`, pulse `rx_complete`, and go to IDLE.
  - If 0: pulse `rx_frame_err`, leave `rx_msg` unchanged, and go to BREAK.
- **BREAK:**
  - Wait until `rx_s == 1`, then go to IDLE.
  - This prevents a stuck-low line or a break condition from generating back-to-back false frames.
- `rx_complete` and `rx_frame_err` are mutually exclusive and never high for 2 consecutive cycles.
- `rx_busy` = (state != IDLE).

## Timing
- Reset values:
  - `rx_msg` = 8'h00, `rx_complete` = 0, `rx_frame_err` = 0, `rx_busy` = 0.
  - State is IDLE; counter, idx and shift register are 0; synchronizer flops are 1.
- `rx_s` lags `rx` by 2 clocks.
- Let t0 be the first edge at which IDLE sees `rx_s` = 0.
  - Start sample is at t0+H.
  - Data bit i is sampled at t0+H+(i+1)·CLKS_PER_BIT, for i = 0..7.
  - Stop bit is sampled at t0+H+9·CLKS_PER_BIT.
- The strobe (`rx_complete` or `rx_frame_err`) is registered high in the cycle after the stop sample, for exactly 1 cycle.
- `rx_msg` changes in the same cycle `rx_complete` rises and then holds until the next good frame.
- Back-to-back frames:
  - IDLE is re-entered by the cycle after the stop sample.
  - A start edge arriving at the nominal stop-bit end (H cycles after the stop sample) must be caught.
  - No inter-frame idle time is required beyond the single stop bit.
- Reset mid-frame:
  - Immediately returns to reset values.
  - No strobe is issued for the aborted frame.
  - After release, the remainder of the interrupted frame must not produce `rx_complete` unless a genuine falling edge is seen from idle-high.
- Reset asserted in the same cycle as a strobe: reset wins, and the strobe is 0.
- Tolerance: at CLKS_PER_BIT ≥ 16, frames whose sender bit period deviates by ±2% must decode correctly.

## Test plan
1. Single byte: CLKS_PER_BIT=8, send 8'h43 ('C') → exactly one `rx_complete` cycle at t0+H+9·8+1 = t0+77 with `rx_msg` = 8'h43; `rx_frame_err` never high.
2. Back-to-back: send "CSL-PU-#" (8'h43, 53, 4C, 2D, 50, 55, 2D, 23) with one stop bit and no idle gap → 8 strobes in that order, each byte matching. Feeding the strobes into the CSL decoder asserts `Go_to_PU`.
3. Glitch rejection: with CLKS_PER_BIT=8, drive `rx` low for 2 clocks then high → `rx_busy` pulses; no `rx_complete` and no `rx_frame_err`; `rx_msg` unchanged.
4. Framing error: send 8'h55 with stop bit low, hold the line low 20 bit times, then release → one `rx_frame_err` pulse; `rx_msg` keeps its previous value; no further strobes until the line goes high. The next valid byte 8'hA5 decodes correctly.
5. Reset mid-frame: assert `rst_n`=0 during data bit 4 of 8'h0F, release, let the frame's tail play out, then send 8'h23 → all outputs at reset values during reset; only 8'h23 is strobed afterwards.
6. Baud skew: CLKS_PER_BIT=16, sender bit periods of 15.7 and 16.3 clocks, send all 256 byte values → 256 correct strobes and zero frame errors.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: oversampled mid-bit sampling, one-cycle strobes for good
// frames and framing errors, break lockout until the line returns high.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_complete,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [1:0]  sync_reg, sync_next;
    logic [1:0]  vld_reg, vld_next;
    logic        arm_reg, arm_next;
    logic [2:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  msg_reg, msg_next;
    logic        complete_reg, complete_next;
    logic        ferr_reg, ferr_next;

    logic rx_s;
    logic bit_done;

    assign rx_s     = sync_reg[1];
    assign bit_done = (cnt_reg == BIT_LAST);

    assign sync_next = {sync_reg[0], rx};
    assign vld_next  = {vld_reg[0], 1'b1};
    // Start edges are only honoured once the real line has been seen high,
    // so the tail of a frame cut by reset cannot masquerade as a new start.
    assign arm_next  = arm_reg | (vld_reg[1] & rx_s);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (state_reg == ST_DATA && bit_done && idx_reg == 3'(gi))
                                    ? rx_s : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        msg_next      = msg_reg;
        complete_next = 1'b0;
        ferr_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = 16'd0;
                idx_next = 3'd0;
                if (arm_reg && !rx_s) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = 16'd0;
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_next = 16'd0;
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_next = 16'd0;
                    if (rx_s) begin
                        msg_next      = shift_reg;
                        complete_next = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_BREAK: begin
                cnt_next = 16'd0;
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = 16'd0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= 2'b11;
            vld_reg      <= 2'b00;
            arm_reg      <= 1'b0;
            state_reg    <= ST_IDLE;
            cnt_reg      <= 16'd0;
            idx_reg      <= 3'd0;
            shift_reg    <= 8'h00;
            msg_reg      <= 8'h00;
            complete_reg <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            sync_reg     <= sync_next;
            vld_reg      <= vld_next;
            arm_reg      <= arm_next;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            msg_reg      <= msg_next;
            complete_reg <= complete_next;
            ferr_reg     <= ferr_next;
        end
    end

    assign rx_msg       = msg_reg;
    assign rx_complete  = complete_reg;
    assign rx_frame_err = ferr_reg;
    assign rx_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: one instance at 8 clocks/bit for the
// functional scenarios, one at 16 clocks/bit for sender baud skew.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx16 = 1'b1;
    logic [7:0] msg8, msg16;
    logic       c8, f8, b8, c16, f16, b16;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int n_c8 = 0, n_f8 = 0, n_c16 = 0, n_f16 = 0;
    int last_c_cyc8 = 0;
    bit prev8 = 1'b0, prev16 = 1'b0;
    logic [7:0] exp_b;
    logic [7:0] q8[$];
    logic [7:0] q16[$];

    localparam int BIT8_NS = 80;

    uart_rx_8n1 #(.CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx(rx8), .rx_msg(msg8),
        .rx_complete(c8), .rx_frame_err(f8), .rx_busy(b8)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx(rx16), .rx_msg(msg16),
        .rx_complete(c16), .rx_frame_err(f16), .rx_busy(b16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe is popped against the queue and checked for
    // exclusivity and single-cycle width.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev8  = 1'b0;
            prev16 = 1'b0;
        end else begin
            if (c8) begin
                n_c8++;
                last_c_cyc8 = cyc;
                tests_run++;
                if (q8.size() == 0) begin
                    tests_failed++;
                    $display("FAIL dut8_unexpected_strobe: got %02h, expected no strobe", msg8);
                end else begin
                    exp_b = q8.pop_front();
                    if (msg8 !== exp_b) begin
                        tests_failed++;
                        $display("FAIL dut8_byte: got %02h, expected %02h", msg8, exp_b);
                    end
                end
            end
            if (f8) n_f8++;
            if (c8 || f8) begin
                tests_run++;
                if ((c8 && f8) || prev8) begin
                    tests_failed++;
                    $display("FAIL dut8_strobe_shape: complete=%b err=%b prev=%b, expected single exclusive pulse", c8, f8, prev8);
                end
            end
            prev8 = c8 | f8;

            if (c16) begin
                n_c16++;
                tests_run++;
                if (q16.size() == 0) begin
                    tests_failed++;
                    $display("FAIL dut16_unexpected_strobe: got %02h, expected no strobe", msg16);
                end else begin
                    exp_b = q16.pop_front();
                    if (msg16 !== exp_b) begin
                        tests_failed++;
                        $display("FAIL dut16_byte: got %02h, expected %02h", msg16, exp_b);
                    end
                end
            end
            if (f16) n_f16++;
            if (c16 || f16) begin
                tests_run++;
                if ((c16 && f16) || prev16) begin
                    tests_failed++;
                    $display("FAIL dut16_strobe_shape: complete=%b err=%b prev=%b, expected single exclusive pulse", c16, f16, prev16);
                end
            end
            prev16 = c16 | f16;
        end
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 8) rx8 = v;
        else          rx16 = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop,
                             input int bit_ns, input bit expect_byte);
        if (expect_byte) begin
            if (sel == 8) q8.push_back(b);
            else          q16.push_back(b);
        end
        drive(sel, 1'b0);
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            #(bit_ns);
        end
        drive(sel, stop);
        #(bit_ns);
        $display("[TB] sent dut%0d byte %02h stop=%b period=%0dns", sel, b, stop, bit_ns);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({msg8, c8, f8, b8} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_dut8: got %03h, expected 000", {msg8, c8, f8, b8});
        end
        tests_run++;
        if ({msg16, c16, f16, b16} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_dut16: got %03h, expected 000", {msg16, c16, f16, b16});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int c0, f0, start_cyc;
        c0 = n_c8; f0 = n_f8;
        @(negedge clk);
        start_cyc = cyc;
        send_byte(8, 8'h43, 1'b1, BIT8_NS, 1'b1);
        #(2 * BIT8_NS);
        tests_run++;
        if (n_c8 - c0 !== 1 || n_f8 - f0 !== 0) begin
            tests_failed++;
            $display("FAIL single_count: complete=%0d err=%0d, expected 1 and 0", n_c8 - c0, n_f8 - f0);
        end
        tests_run++;
        if (last_c_cyc8 - start_cyc !== 79) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d clocks, expected 79", last_c_cyc8 - start_cyc);
        end
        tests_run++;
        if (msg8 !== 8'h43) begin
            tests_failed++;
            $display("FAIL single_hold: got %02h, expected 43", msg8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg_bytes [8] = '{8'h43, 8'h53, 8'h4C, 8'h2D, 8'h50, 8'h55, 8'h2D, 8'h23};
        int c0, f0;
        c0 = n_c8; f0 = n_f8;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(8, msg_bytes[i], 1'b1, BIT8_NS, 1'b1);
        #(2 * BIT8_NS);
        tests_run++;
        if (n_c8 - c0 !== 8 || n_f8 - f0 !== 0 || q8.size() !== 0) begin
            tests_failed++;
            $display("FAIL b2b_count: complete=%0d err=%0d pending=%0d, expected 8 0 0", n_c8 - c0, n_f8 - f0, q8.size());
        end
    endtask

    task automatic test_glitch();
        int c0, f0;
        logic [7:0] m0;
        bit saw_busy;
        c0 = n_c8; f0 = n_f8; m0 = msg8; saw_busy = 1'b0;
        @(negedge clk);
        rx8 = 1'b0;
        repeat (2) @(negedge clk);
        rx8 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b8) saw_busy = 1'b1;
        end
        $display("[TB] glitch pulse done, busy seen=%b", saw_busy);
        tests_run++;
        if (!saw_busy || b8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: seen=%b now=%b, expected 1 then 0", saw_busy, b8);
        end
        tests_run++;
        if (n_c8 - c0 !== 0 || n_f8 - f0 !== 0 || msg8 !== m0) begin
            tests_failed++;
            $display("FAIL glitch_silent: complete=%0d err=%0d msg=%02h, expected 0 0 %02h", n_c8 - c0, n_f8 - f0, msg8, m0);
        end
    endtask

    task automatic test_frame_err();
        int c0, f0;
        logic [7:0] m0;
        c0 = n_c8; f0 = n_f8; m0 = msg8;
        @(negedge clk);
        send_byte(8, 8'h55, 1'b0, BIT8_NS, 1'b0);
        #(20 * BIT8_NS);
        tests_run++;
        if (n_f8 - f0 !== 1 || n_c8 - c0 !== 0 || b8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL ferr_break: err=%0d complete=%0d busy=%b, expected 1 0 1", n_f8 - f0, n_c8 - c0, b8);
        end
        tests_run++;
        if (msg8 !== m0) begin
            tests_failed++;
            $display("FAIL ferr_msg_hold: got %02h, expected %02h", msg8, m0);
        end
        @(negedge clk);
        rx8 = 1'b1;
        #(2 * BIT8_NS);
        tests_run++;
        if (b8 !== 1'b0 || n_f8 - f0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_release: busy=%b err=%0d, expected 0 1", b8, n_f8 - f0);
        end
        send_byte(8, 8'hA5, 1'b1, BIT8_NS, 1'b1);
        #(2 * BIT8_NS);
        tests_run++;
        if (n_c8 - c0 !== 1 || msg8 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL ferr_recover: complete=%0d msg=%02h, expected 1 A5", n_c8 - c0, msg8);
        end
    endtask

    task automatic test_reset_midframe();
        int c0, f0;
        c0 = n_c8; f0 = n_f8;
        @(negedge clk);
        fork
            send_byte(8, 8'h0F, 1'b1, BIT8_NS, 1'b0);
            begin
                #(5 * BIT8_NS + BIT8_NS / 2);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                tests_run++;
                if ({msg8, c8, f8, b8} !== 11'h000) begin
                    tests_failed++;
                    $display("FAIL midreset_values: got %03h, expected 000", {msg8, c8, f8, b8});
                end
                rst_n = 1'b1;
            end
        join
        #(12 * BIT8_NS);
        tests_run++;
        if (n_c8 - c0 !== 0 || n_f8 - f0 !== 0) begin
            tests_failed++;
            $display("FAIL midreset_tail: complete=%0d err=%0d, expected 0 0", n_c8 - c0, n_f8 - f0);
        end
        send_byte(8, 8'h23, 1'b1, BIT8_NS, 1'b1);
        #(2 * BIT8_NS);
        tests_run++;
        if (n_c8 - c0 !== 1 || msg8 !== 8'h23) begin
            tests_failed++;
            $display("FAIL midreset_next: complete=%0d msg=%02h, expected 1 23", n_c8 - c0, msg8);
        end
    endtask

    task automatic test_baud_skew();
        int c0, f0;
        c0 = n_c16; f0 = n_f16;
        @(negedge clk);
        for (int v = 0; v < 256; v++) begin
            send_byte(16, 8'(v), 1'b1, (v % 2 == 1) ? 163 : 157, 1'b1);
        end
        #(3 * 160);
        tests_run++;
        if (n_c16 - c0 !== 256 || n_f16 - f0 !== 0 || q16.size() !== 0) begin
            tests_failed++;
            $display("FAIL skew_count: complete=%0d err=%0d pending=%0d, expected 256 0 0", n_c16 - c0, n_f16 - f0, q16.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_baud_skew();
        tests_run++;
        if (q8.size() !== 0 || q16.size() !== 0) begin
            tests_failed++;
            $display("FAIL final_queues: pending %0d/%0d, expected 0/0", q8.size(), q16.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
